insn_decode_stage: RTL and testbench
====================================

// Module: insn_decode_stage
// PURPOSE
//   Registered, parametrised decode stage between fetch and execute.
//   - Classifies the opcode into a one-hot class vector and extracts register fields, immediate and target.
//   - valid/ready handshake on both sides; flush input for taken branches.
//   - Load-use hazard detection with bubble insertion and a saturating stall counter.
// PARAMETERS
//   XLEN    32  instruction / immediate width
//   OPW     5   opcode width, insn[XLEN-1 -: OPW]
//   REGW    5   register index width
//   NCLASS  11  class vector width: r,ri,sw,lw,j,bne,jal,jr,blt,bex,setx (bit 0..10)
//   STALLW  16  stall counter width
// PORTS
//   clock        in   1        rising-edge clock
//   reset_n      in   1        asynchronous, active-low reset
//   in_valid     in   1        fetch presents in_insn
//   in_ready     out  1        stage accepts in_insn this cycle
//   in_insn      in   XLEN     raw instruction
//   flush        in   1        kill held insn; block input this cycle
//   out_valid    out  1        registered insn valid
//   out_ready    in   1        execute consumes registered insn
//   out_class    out  NCLASS   one-hot class; all-zero when illegal
//   out_illegal  out  1        opcode matched no class
//   out_rd       out  REGW     dest/source field; 31 for jal, 30 for setx
//   out_rs       out  REGW     insn[21:17]
//   out_rt       out  REGW     insn[16:12]; 30 for bex
//   out_imm      out  XLEN     sign-extended insn[16:0]
//   out_target   out  XLEN     zero-extended insn[26:0]
//   stall_cnt    out  STALLW   load-use bubble cycles, saturating
// BEHAVIOUR
//   Reset: all outputs 0; in_ready is combinational, 1 after reset.
//   Opcodes: r=00000, ri=00101, sw=00111, lw=01000, j=00001, bne=00010, jal=00011,
//     jr=00100, blt=00110, bex=10110, setx=10101. Anything else is illegal.
//   Latency: 1 cycle, in_insn accepted at edge N -> out_* valid after edge N.
//   hold   = out_valid & ~out_ready.
//   Source use by class:
//     r: rs,rt | ri,lw: rs | sw,bne,blt: rd,rs | jr: rd | bex: r30 | j,jal,setx: none.
//   hazard = in_valid & out_valid & out_class[lw] & out_rd!=0
//            & an incoming used source == out_rd.
//   in_ready = ~flush & ~hazard & ~hold.
//   Edge priority, highest first:
//     1. flush: out_valid<=0.
//     2. hold: all out_* keep their values.
//     3. hazard: out_valid<=0 (bubble); in_insn is re-presented next cycle.
//     4. in_valid & in_ready: load the decoded fields; out_valid<=1.
//     5. Otherwise: out_valid<=0.
//   Handshake rules:
//     - A presented insn stays stable until accepted.
//     - Fields are don't-care while out_valid=0, but hold their last value.
//   stall_cnt increments on every cycle with hazard=1, including hazard & hold.
//     - Sticks at 2^STALLW-1; never wraps.
//     - Cleared only by reset.
//   Illegal opcode is passed through with out_illegal=1 and no hazard from it.
//   Reset asserted mid-transfer drops the held insn; no partial state survives.
//   Simultaneous flush & hazard: flush wins, no stall counted? No: the counter
//     still counts, because hazard is evaluated independently of flush.
// STRUCTURE
//   Package isa_pkg:
//     - OP_* opcode localparams.
//     - CLS_* class bit indices.
//     - REG_RA=31, REG_STATUS=30.
//   Sub-module insn_class_decode:
//     - Combinational opcode -> one-hot class + illegal.
//     - Parametrised on OPW / NCLASS.
//   Top level: field extraction, hazard compare, pipeline register, counter.
// TESTING
//   1. reset_n=0 mid-stream -> out_valid=0, stall_cnt=0; in_ready=1 next cycle.
//   2. Each of 11 opcodes + 5'b11111, out_ready=1 -> correct one-hot; 11111 gives illegal=1, class=0.
//   3. lw r5 then add r1,r5,r2 -> one bubble cycle, add valid 2 cycles after lw, stall_cnt=1.
//   4. lw r0 then add r1,r0,r0 -> no bubble; lw r30 then bex -> one bubble.
//   5. out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0; release -> next insn 1 cycle later.
//   6. flush with out_valid=1 and in_valid=1 -> out_valid=0 next edge, in_insn not consumed.
//   7. Force stall_cnt to 16'hFFFE, then 3 hazards -> stall_cnt=16'hFFFF and stays there.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA constants for the decode stage: opcodes, class bit indices and
// the architectural registers that some instructions use implicitly.
package isa_pkg;

    typedef enum logic [4:0] {
        OP_R    = 5'b00000,
        OP_J    = 5'b00001,
        OP_BNE  = 5'b00010,
        OP_JAL  = 5'b00011,
        OP_JR   = 5'b00100,
        OP_RI   = 5'b00101,
        OP_BLT  = 5'b00110,
        OP_SW   = 5'b00111,
        OP_LW   = 5'b01000,
        OP_SETX = 5'b10101,
        OP_BEX  = 5'b10110
    } opcode_e;

    localparam int CLS_R    = 0;
    localparam int CLS_RI   = 1;
    localparam int CLS_SW   = 2;
    localparam int CLS_LW   = 3;
    localparam int CLS_J    = 4;
    localparam int CLS_BNE  = 5;
    localparam int CLS_JAL  = 6;
    localparam int CLS_JR   = 7;
    localparam int CLS_BLT  = 8;
    localparam int CLS_BEX  = 9;
    localparam int CLS_SETX = 10;
    localparam int NUM_OPS  = 11;

    // Opcode owning each class bit, indexed by CLS_*.
    localparam opcode_e CLASS_OP [NUM_OPS] = '{
        OP_R, OP_RI, OP_SW, OP_LW, OP_J, OP_BNE, OP_JAL, OP_JR, OP_BLT, OP_BEX, OP_SETX
    };

    localparam logic [4:0] REG_RA     = 5'd31;
    localparam logic [4:0] REG_STATUS = 5'd30;

endpackage

// File: rtl/insn_class_decode.sv
// Combinational opcode classifier: one-hot class vector, illegal when no bit
// is set. Class bits beyond the defined opcodes are tied low.
module insn_class_decode
    import isa_pkg::*;
#(
    parameter int OPW    = 5,
    parameter int NCLASS = 11
) (
    input  logic [OPW-1:0]    i_op,
    output logic [NCLASS-1:0] o_class,
    output logic              o_illegal
);

    for (genvar k = 0; k < NCLASS; k++) begin : g_cls
        if (k < NUM_OPS) begin : g_op
            assign o_class[k] = (i_op == OPW'(CLASS_OP[k]));
        end else begin : g_none
            assign o_class[k] = 1'b0;
        end
    end

    assign o_illegal = ~|o_class;

endmodule

// File: rtl/insn_decode_stage.sv
// Registered decode stage between fetch and execute: classifies the opcode,
// extracts fields, and inserts a bubble on a load-use hazard.
module insn_decode_stage
    import isa_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int OPW    = 5,
    parameter int REGW   = 5,
    parameter int NCLASS = 11,
    parameter int STALLW = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_insn,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCLASS-1:0] out_class,
    output logic              out_illegal,
    output logic [REGW-1:0]   out_rd,
    output logic [REGW-1:0]   out_rs,
    output logic [REGW-1:0]   out_rt,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_target,
    output logic [STALLW-1:0] stall_cnt
);

    localparam int TGTW = XLEN - OPW;
    localparam int IMMW = XLEN - OPW - 2 * REGW;

    logic [NCLASS-1:0] w_cls;
    logic              w_illegal;
    logic [REGW-1:0]   w_rd_fld, w_rs_fld, w_rt_fld;
    logic [REGW-1:0]   w_rd, w_rt;
    logic [XLEN-1:0]   w_imm, w_tgt;
    logic              w_use_rd, w_use_rs, w_use_rt, w_use_st;
    logic              w_ld_pending, w_hazard, w_hold;

    logic              r_valid;
    logic [NCLASS-1:0] r_class;
    logic              r_illegal;
    logic [REGW-1:0]   r_rd, r_rs, r_rt;
    logic [XLEN-1:0]   r_imm, r_target;
    logic [STALLW-1:0] r_stall;

    insn_class_decode #(
        .OPW    (OPW),
        .NCLASS (NCLASS)
    ) u_cls (
        .i_op      (in_insn[XLEN-1 -: OPW]),
        .o_class   (w_cls),
        .o_illegal (w_illegal)
    );

    assign w_rd_fld = in_insn[TGTW-1 -: REGW];
    assign w_rs_fld = in_insn[TGTW-REGW-1 -: REGW];
    assign w_rt_fld = in_insn[IMMW-1 -: REGW];
    assign w_imm    = {{(XLEN-IMMW){in_insn[IMMW-1]}}, in_insn[IMMW-1:0]};
    assign w_tgt    = {{OPW{1'b0}}, in_insn[TGTW-1:0]};

    // jal writes the return-address register, setx/bex use the status register.
    assign w_rd = w_cls[CLS_JAL]  ? REGW'(REG_RA)     :
                  w_cls[CLS_SETX] ? REGW'(REG_STATUS) : w_rd_fld;
    assign w_rt = w_cls[CLS_BEX]  ? REGW'(REG_STATUS) : w_rt_fld;

    assign w_use_rd = w_cls[CLS_SW] | w_cls[CLS_BNE] | w_cls[CLS_BLT] | w_cls[CLS_JR];
    assign w_use_rs = w_cls[CLS_R] | w_cls[CLS_RI] | w_cls[CLS_LW]
                    | w_cls[CLS_SW] | w_cls[CLS_BNE] | w_cls[CLS_BLT];
    assign w_use_rt = w_cls[CLS_R];
    assign w_use_st = w_cls[CLS_BEX];

    // r0 is hardwired, so a load into it never creates a dependency.
    assign w_ld_pending = r_valid & r_class[CLS_LW] & (r_rd != '0);
    assign w_hazard = in_valid & w_ld_pending &
                      ((w_use_rd & (w_rd_fld == r_rd)) |
                       (w_use_rs & (w_rs_fld == r_rd)) |
                       (w_use_rt & (w_rt_fld == r_rd)) |
                       (w_use_st & (REGW'(REG_STATUS) == r_rd)));

    assign w_hold   = r_valid & ~out_ready;
    assign in_ready = ~flush & ~w_hazard & ~w_hold;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= 1'b0;
            r_class   <= '0;
            r_illegal <= 1'b0;
            r_rd      <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_imm     <= '0;
            r_target  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_hold) begin
            r_valid <= r_valid;
        end else if (w_hazard) begin
            r_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            r_valid   <= 1'b1;
            r_class   <= w_cls;
            r_illegal <= w_illegal;
            r_rd      <= w_rd;
            r_rs      <= w_rs_fld;
            r_rt      <= w_rt;
            r_imm     <= w_imm;
            r_target  <= w_tgt;
        end else begin
            r_valid <= 1'b0;
        end
    end

    // Counts every hazard cycle, independent of flush and hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall <= '0;
        end else if (w_hazard && (r_stall != '1)) begin
            r_stall <= r_stall + STALLW'(1);
        end
    end

    assign out_valid   = r_valid;
    assign out_class   = r_class;
    assign out_illegal = r_illegal;
    assign out_rd      = r_rd;
    assign out_rs      = r_rs;
    assign out_rt      = r_rt;
    assign out_imm     = r_imm;
    assign out_target  = r_target;
    assign stall_cnt   = r_stall;

endmodule

// File: tb/tb_insn_decode_stage.sv
// Directed bench for insn_decode_stage with a decode model feeding a
// scoreboard queue; outputs are sampled on the falling edge.
module tb_insn_decode_stage;

    logic        clock, reset_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
    logic [31:0] in_insn, out_imm, out_target;
    logic [10:0] out_class;
    logic [4:0]  out_rd, out_rs, out_rt;
    logic [15:0] stall_cnt;

    insn_decode_stage dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_insn     (in_insn),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_class   (out_class),
        .out_illegal (out_illegal),
        .out_rd      (out_rd),
        .out_rs      (out_rs),
        .out_rt      (out_rt),
        .out_imm     (out_imm),
        .out_target  (out_target),
        .stall_cnt   (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [10:0] cls;
        logic        ill;
        logic [4:0]  rd, rs, rt;
        logic [31:0] imm, tgt;
    } exp_t;

    exp_t sbq [$];
    int   ncmp = 0;
    int   nfail = 0;

    function automatic logic [31:0] mk(logic [4:0] op, logic [4:0] rd, logic [4:0] rs,
                                       logic [4:0] rt, logic [11:0] lo);
        return {op, rd, rs, rt, lo};
    endfunction

    function automatic exp_t model(logic [31:0] insn);
        exp_t       e;
        logic [4:0] op;
        op    = insn[31:27];
        e.cls = '0;
        case (op)
            5'b00000: e.cls[0]  = 1'b1;
            5'b00101: e.cls[1]  = 1'b1;
            5'b00111: e.cls[2]  = 1'b1;
            5'b01000: e.cls[3]  = 1'b1;
            5'b00001: e.cls[4]  = 1'b1;
            5'b00010: e.cls[5]  = 1'b1;
            5'b00011: e.cls[6]  = 1'b1;
            5'b00100: e.cls[7]  = 1'b1;
            5'b00110: e.cls[8]  = 1'b1;
            5'b10110: e.cls[9]  = 1'b1;
            5'b10101: e.cls[10] = 1'b1;
            default:  e.cls     = '0;
        endcase
        e.ill = (e.cls == '0);
        e.rd  = (op == 5'b00011) ? 5'd31 : (op == 5'b10101) ? 5'd30 : insn[26:22];
        e.rs  = insn[21:17];
        e.rt  = (op == 5'b10110) ? 5'd30 : insn[16:12];
        e.imm = {{15{insn[16]}}, insn[16:0]};
        e.tgt = {5'b0, insn[26:0]};
        return e;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Falling-edge scoreboard step, then advance past the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        if (out_valid && out_ready) begin
            chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("sb_class", 64'(out_class), 64'(e.cls));
                chk("sb_illegal", 64'(out_illegal), 64'(e.ill));
                chk("sb_rd", 64'(out_rd), 64'(e.rd));
                chk("sb_rs", 64'(out_rs), 64'(e.rs));
                chk("sb_rt", 64'(out_rt), 64'(e.rt));
                chk("sb_imm", 64'(out_imm), 64'(e.imm));
                chk("sb_target", 64'(out_target), 64'(e.tgt));
            end
        end
        if (reset_n && in_valid && in_ready) sbq.push_back(model(in_insn));
        @(posedge clock);
        #1;
    endtask

    task automatic drive(logic v, logic [31:0] insn);
        in_valid = v;
        in_insn  = insn;
        #1;
    endtask

    logic [4:0] ops [12] = '{5'b00000, 5'b00101, 5'b00111, 5'b01000, 5'b00001, 5'b00010,
                             5'b00011, 5'b00100, 5'b00110, 5'b10110, 5'b10101, 5'b11111};

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_insn = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        chk("rst_class", 64'(out_class), 64'd0);
        chk("rst_imm", 64'(out_imm), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        reset_n = 1'b1;

        // All opcodes plus one illegal, back to back.
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, mk(ops[k], 5'($urandom_range(31)), 5'($urandom_range(31)),
                           5'($urandom_range(31)), 12'($urandom_range(4095))));
            chk("opc_in_ready", 64'(in_ready), 64'd1);
            tick();
        end
        drive(1'b0, '0);
        chk("opc_last_valid", 64'(out_valid), 64'd1);
        chk("opc_last_illegal", 64'(out_illegal), 64'd1);
        tick();
        chk("opc_drained", 64'(out_valid), 64'd0);

        // lw r5 ; add r1,r5,r2 -> one bubble.
        drive(1'b1, mk(5'b01000, 5'd5, 5'd1, 5'd0, 12'h004));
        tick();
        drive(1'b1, mk(5'b00000, 5'd1, 5'd5, 5'd2, 12'h000));
        chk("lu_in_ready", 64'(in_ready), 64'd0);
        chk("lu_lw_valid", 64'(out_valid), 64'd1);
        tick();
        drive(1'b1, mk(5'b00000, 5'd1, 5'd5, 5'd2, 12'h000));
        chk("lu_bubble", 64'(out_valid), 64'd0);
        chk("lu_stall", 64'(stall_cnt), 64'd1);
        chk("lu_retry_ready", 64'(in_ready), 64'd1);
        tick();
        drive(1'b0, '0);
        chk("lu_add_valid", 64'(out_valid), 64'd1);
        tick();

        // lw r0 never hazards; lw r30 then bex does.
        drive(1'b1, mk(5'b01000, 5'd0, 5'd3, 5'd0, 12'h008));
        tick();
        drive(1'b1, mk(5'b00000, 5'd1, 5'd0, 5'd0, 12'h000));
        chk("r0_in_ready", 64'(in_ready), 64'd1);
        tick();
        drive(1'b0, '0);
        chk("r0_add_valid", 64'(out_valid), 64'd1);
        chk("r0_stall", 64'(stall_cnt), 64'd1);
        tick();
        drive(1'b1, mk(5'b01000, 5'd30, 5'd3, 5'd0, 12'h00c));
        tick();
        drive(1'b1, mk(5'b10110, 5'd0, 5'd0, 5'd0, 12'h123));
        chk("bex_in_ready", 64'(in_ready), 64'd0);
        tick();
        drive(1'b1, mk(5'b10110, 5'd0, 5'd0, 5'd0, 12'h123));
        chk("bex_bubble", 64'(out_valid), 64'd0);
        chk("bex_stall", 64'(stall_cnt), 64'd2);
        tick();
        drive(1'b0, '0);
        chk("bex_valid", 64'(out_valid), 64'd1);
        tick();

        // Backpressure for three cycles.
        drive(1'b1, mk(5'b00101, 5'd4, 5'd6, 5'd7, 12'h9ab));
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, mk(5'b00000, 5'd8, 5'd9, 5'd10, 12'h000));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_rd", 64'(out_rd), 64'(sbq[0].rd));
            chk("bp_imm", 64'(out_imm), 64'(sbq[0].imm));
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        tick();
        drive(1'b0, '0);
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        tick();

        // Flush kills the held insn and blocks the presented one for a cycle.
        drive(1'b1, mk(5'b00111, 5'd11, 5'd12, 5'd0, 12'h010));
        tick();
        out_ready = 1'b0;
        flush = 1'b1;
        drive(1'b1, mk(5'b00110, 5'd13, 5'd14, 5'd0, 12'hfff));
        chk("fl_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        void'(sbq.pop_front());
        #1;
        chk("fl_killed", 64'(out_valid), 64'd0);
        chk("fl_in_ready_after", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick();
        drive(1'b0, '0);
        chk("fl_next_valid", 64'(out_valid), 64'd1);
        tick();

        // Reset mid-transfer with a held load and a pending hazard.
        out_ready = 1'b0;
        drive(1'b1, mk(5'b01000, 5'd7, 5'd1, 5'd0, 12'h000));
        tick();
        drive(1'b1, mk(5'b00000, 5'd2, 5'd7, 5'd3, 12'h000));
        tick();
        chk("mr_hold_stall", 64'(stall_cnt), 64'd3);
        reset_n = 1'b0;
        #1;
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_stall", 64'(stall_cnt), 64'd0);
        chk("mr_rd", 64'(out_rd), 64'd0);
        sbq.delete();
        drive(1'b0, '0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        chk("mr_in_ready", 64'(in_ready), 64'd1);

        // Saturation: a held load with a dependent insn hazards every cycle.
        drive(1'b1, mk(5'b01000, 5'd9, 5'd1, 5'd0, 12'h000));
        tick();
        drive(1'b1, mk(5'b00000, 5'd1, 5'd9, 5'd9, 12'h000));
        repeat (65534) @(posedge clock);
        #1;
        chk("sat_fffe", 64'(stall_cnt), 64'hfffe);
        repeat (3) @(posedge clock);
        #1;
        chk("sat_ffff", 64'(stall_cnt), 64'hffff);
        repeat (2) @(posedge clock);
        #1;
        chk("sat_stick", 64'(stall_cnt), 64'hffff);
        out_ready = 1'b1;
        tick();
        chk("sat_bubble", 64'(out_valid), 64'd0);
        tick();
        drive(1'b0, '0);
        chk("sat_add_valid", 64'(out_valid), 64'd1);
        tick();
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
